// File: rtl/piso_stream.sv
// piso_stream: parallel-in/serial-out serializer with a valid/ready input
// handshake, a one-word holding buffer for gap-free back-to-back words,
// selectable bit order and a framing strobe.
//
// Optional feature: define PISO_STREAM_PARITY_EN to append one even-parity
// bit after every word. In that build a PARITY state follows each word's last
// data bit, with frame low and done high. The default build has no parity.
module piso_stream #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef PISO_STREAM_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   sr, sr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]   hold;
  logic               hold_valid, hold_valid_n;
  logic               hold_load;
  logic               accept;
  logic               last_bit;
  logic               word_end;
  logic [WIDTH-1:0]   sr_shifted;
`ifdef PISO_STREAM_PARITY_EN
  logic               par, par_n;
`endif

  // The handshake depends only on registered state, never on din_valid.
  assign din_ready  = !hold_valid;
  assign accept     = din_valid && din_ready;
  assign last_bit   = (cnt == CNT_W'(WIDTH - 1));
  assign sr_shifted = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

  // The edge at which the current word is finished and the next may start.
`ifdef PISO_STREAM_PARITY_EN
  assign word_end = (state == PARITY);
`else
  assign word_end = (state == SHIFT) && last_bit;
`endif

  // Next-state logic for the FSM, shift register, counter and hold flag.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the branches below can leave one unassigned and infer a latch.
    state_n      = state;
    sr_n         = sr;
    cnt_n        = cnt;
    hold_valid_n = hold_valid;
    hold_load    = 1'b0;
`ifdef PISO_STREAM_PARITY_EN
    par_n        = par;
`endif
    if (word_end) begin
      if (hold_valid) begin
        sr_n         = hold;
        cnt_n        = '0;
        hold_valid_n = 1'b0;
        state_n      = SHIFT;
`ifdef PISO_STREAM_PARITY_EN
        par_n        = ^hold;
`endif
      end else if (accept) begin
        sr_n    = din;
        cnt_n   = '0;
        state_n = SHIFT;
`ifdef PISO_STREAM_PARITY_EN
        par_n   = ^din;
`endif
      end else begin
        state_n = IDLE;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sr_n    = din;
            cnt_n   = '0;
            state_n = SHIFT;
`ifdef PISO_STREAM_PARITY_EN
            par_n   = ^din;
`endif
          end
        end
        SHIFT: begin
          // A word offered while another is in flight waits in hold.
          if (accept) begin
            hold_load    = 1'b1;
            hold_valid_n = 1'b1;
          end
          if (!last_bit) begin
            cnt_n = cnt + CNT_W'(1);
            sr_n  = sr_shifted;
          end
`ifdef PISO_STREAM_PARITY_EN
          else begin
            state_n = PARITY;
          end
`endif
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Control and shift state; a reset discards any partially sent word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sr         <= '0;
      cnt        <= '0;
      hold_valid <= 1'b0;
`ifdef PISO_STREAM_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values computed above.
      state      <= state_n;
      sr         <= sr_n;
      cnt        <= cnt_n;
      hold_valid <= hold_valid_n;
`ifdef PISO_STREAM_PARITY_EN
      par        <= par_n;
`endif
    end
  end

  // Holding buffer data.
  // NOTE: hold is a data-only register qualified by hold_valid, so it needs
  // no reset; only the valid flag is cleared.
  always_ff @(posedge clk) begin
    if (hold_load) hold <= din;
  end

  // Serial outputs decoded from registered state only.
  always_comb begin
    dout  = IDLE_LEVEL;
    frame = 1'b0;
    done  = 1'b0;
    unique case (state)
      SHIFT: begin
        dout  = MSB_FIRST ? sr[WIDTH-1] : sr[0];
        frame = 1'b1;
`ifndef PISO_STREAM_PARITY_EN
        done  = last_bit;
`endif
      end
`ifdef PISO_STREAM_PARITY_EN
      PARITY: begin
        dout = par;
        done = 1'b1;
      end
`endif
      default: begin
        dout  = IDLE_LEVEL;
        frame = 1'b0;
        done  = 1'b0;
      end
    endcase
  end

  assign busy = (state != IDLE) || hold_valid;

endmodule

// File: tb/tb_piso_stream.sv
// Testbench for piso_stream: two instances (MSB-first idling low, LSB-first
// idling high) share one producer. A per-cycle scoreboard queue per instance
// holds the expected dout/frame/done for every future cycle; words are pushed
// on acceptance and entries popped each cycle at the falling edge.
module tb_piso_stream;

  localparam int WIDTH = 8;
`ifdef PISO_STREAM_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int P   = WIDTH + 1;
`else
  localparam bit PAR = 1'b0;
  localparam int P   = WIDTH;
`endif

  typedef struct packed {
    logic d;
    logic f;
    logic dn;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             dout_m, frame_m, busy_m, done_m, ready_m;
  logic             dout_l, frame_l, busy_l, done_l, ready_l;

  ent_t q_m[$];
  ent_t q_l[$];
  bit   exp_ready = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  piso_stream #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(ready_m), .dout(dout_m), .frame(frame_m), .busy(busy_m),
    .done(done_m)
  );

  piso_stream #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(ready_l), .dout(dout_l), .frame(frame_l), .busy(busy_l),
    .done(done_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected cycle-by-cycle output of one accepted word, both bit orders.
  task automatic push_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) begin
      q_m.push_back('{d: w[WIDTH-1-i], f: 1'b1, dn: (!PAR && i == WIDTH-1)});
      q_l.push_back('{d: w[i],         f: 1'b1, dn: (!PAR && i == WIDTH-1)});
    end
    if (PAR) begin
      q_m.push_back('{d: ^w, f: 1'b0, dn: 1'b1});
      q_l.push_back('{d: ^w, f: 1'b0, dn: 1'b1});
    end
  endtask

  // Compare both instances against the scoreboard for the current cycle.
  task automatic check_outputs();
    ent_t em, el;
    bit   have;
    have = (q_m.size() > 0);
    if (have) begin
      em = q_m.pop_front();
      el = q_l.pop_front();
    end else begin
      em = '{d: 1'b0, f: 1'b0, dn: 1'b0};
      el = '{d: 1'b1, f: 1'b0, dn: 1'b0};
    end
    // A second word sits in hold exactly when a whole word is queued
    // behind the remainder of the current one.
    exp_ready = (q_m.size() < P);
    check("msb_dout",  dout_m,  em.d);
    check("msb_frame", frame_m, em.f);
    check("msb_done",  done_m,  em.dn);
    check("msb_busy",  busy_m,  have);
    check("msb_ready", ready_m, exp_ready);
    check("lsb_dout",  dout_l,  el.d);
    check("lsb_frame", frame_l, el.f);
    check("lsb_done",  done_l,  el.dn);
    check("lsb_busy",  busy_l,  have);
    check("lsb_ready", ready_l, exp_ready);
  endtask

  // One clock cycle: note any acceptance at the rising edge, check at the falling edge.
  task automatic step(output bit acc);
    @(posedge clk);
    acc = din_valid && exp_ready && (rst_n === 1'b1);
    if (acc) push_word(din);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    bit acc;
    din_valid = 1'b0;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  // Offer a word and leave din_valid high once it is taken.
  task automatic send(input logic [WIDTH-1:0] w);
    bit acc;
    acc       = 1'b0;
    din       = w;
    din_valid = 1'b1;
    for (int k = 0; k < 40 && !acc; k++) step(acc);
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;

    // Reset state, including an offer that must be ignored while in reset.
    #1 check_outputs();
    idle(2);
    din       = 8'h3C;
    din_valid = 1'b1;
    begin
      bit acc;
      step(acc);
    end
    din_valid = 1'b0;
    #2 rst_n = 1'b1;

    // Single word, then back to idle.
    send(8'h55);
    idle(12);

    // Back-to-back words with din_valid held high, then a long quiet gap.
    send(8'hAA);
    send(8'h0F);
    idle(20);

    // Bit-order check word (LSB instance sends 1,0,1,1,0,0,1,1).
    send(8'hCD);
    idle(12);

    // Parity-oriented words (plain words in the default build).
    send(8'h80);
    send(8'hF0);
    idle(12);

    // Reset mid-word after three bits of 8'hAA.
    send(8'hAA);
    din_valid = 1'b0;
    idle(2);
    #2 rst_n = 1'b0;
    q_m.delete();
    q_l.delete();
    exp_ready = 1'b1;
    #1 check_outputs();
    din       = 8'h0F;
    din_valid = 1'b1;
    begin
      bit acc;
      step(acc);
      step(acc);
    end
    #2 rst_n = 1'b1;
    send(8'h0F);
    idle(12);

    // Random words with random gaps.
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
      send(WIDTH'($urandom));
    end
    idle(30);

    check("queue_drained", q_m.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
